axi_aw_burst_gen: RTL and testbench

Downstream consumer of the AXI write-address (AW) channel. Accepts AW requests (awid/awlen/awaddr) through a valid/ready handshake and queues them in a small FIFO. It then expands each request into awlen+1 per-beat INCR addresses on a valid/ready beat stream. That stream feeds the write-data/memory stage behind sample_dut.

---
 rtl/axi_aw_pkg.sv | 19 +
 rtl/axi_aw_burst_gen_sync_fifo.sv | 56 +++++
 rtl/axi_aw_burst_gen.sv | 153 +++++++++++++++
 tb/tb_axi_aw_burst_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_aw_pkg.sv
// Shared types and default widths for the AW burst generator slice.
package axi_aw_pkg;

    localparam int unsigned ID_W_DEF   = 4;
    localparam int unsigned LEN_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF = 32;

    typedef struct packed {
        logic [ID_W_DEF-1:0]   id;
        logic [LEN_W_DEF-1:0]  len;
        logic [ADDR_W_DEF-1:0] addr;
    } aw_entry_t;

    typedef enum logic {
        IDLE,
        BURST
    } aw_state_e;

endpackage

// File: rtl/axi_aw_burst_gen_sync_fifo.sv
// Small synchronous FIFO with occupancy count; pop on empty and push on full are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (cnt != CW'(DEPTH));
    assign do_pop  = pop && (cnt != '0);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axi_aw_burst_gen.sv
// AW channel consumer: queues AW requests and expands each into awlen+1 INCR beat addresses.
module axi_aw_burst_gen
    import axi_aw_pkg::*;
#(
    parameter int unsigned ID_W       = ID_W_DEF,
    parameter int unsigned LEN_W      = LEN_W_DEF,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_W-1:0]         awid,
    input  logic [LEN_W-1:0]        awlen,
    input  logic [ADDR_W-1:0]       awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    output logic                    beat_valid,
    input  logic                    beat_ready,
    output logic [ADDR_W-1:0]       beat_addr,
    output logic [ID_W-1:0]         beat_id,
    output logic [LEN_W-1:0]        beat_idx,
    output logic                    beat_last,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned EW    = ID_W + LEN_W + ADDR_W;
    localparam int unsigned SHIFT = $clog2(DATA_BYTES);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t            in_e;
    entry_t            head;
    logic [EW-1:0]     head_raw;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;
    logic              q_nonempty;

    aw_state_e         state;
    aw_state_e         state_nx;

    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  idx_q;
    logic [ID_W-1:0]   id_q;
    logic              last_q;
    logic              avail_q;

    logic [ADDR_W-1:0] align_base;
    logic [LEN_W:0]    idx_inc;
    logic [ADDR_W-1:0] next_addr;

    assign in_e       = '{id: awid, len: awlen, addr: awaddr};
    assign head       = entry_t'(head_raw);
    assign q_nonempty = (cnt != '0);
    assign awready    = !rst && (cnt < CW'(DEPTH));
    assign push       = awvalid && awready;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_e),
        .pop   (pop),
        .dout  (head_raw),
        .count (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Leaving IDLE waits on a registered copy of "queue non-empty", giving the
    // two-edge AW-to-beat latency; the last-beat reload path uses the live count.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (avail_q && q_nonempty) begin
                    pop      = 1'b1;
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (beat_ready && last_q) begin
                    if (q_nonempty) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        beat_valid = (state == BURST);
    end

    assign align_base = start_q & ~ADDR_W'(DATA_BYTES - 1);
    assign idx_inc    = {1'b0, idx_q} + (LEN_W + 1)'(1);
    assign next_addr  = align_base + (ADDR_W'(idx_inc) << SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
            avail_q <= 1'b0;
        end else begin
            avail_q <= q_nonempty;
            if (pop) begin
                id_q    <= head.id;
                start_q <= head.addr;
                addr_q  <= head.addr;
                rem_q   <= head.len;
                idx_q   <= '0;
                last_q  <= (head.len == '0);
            end else if (beat_valid && beat_ready && !last_q) begin
                idx_q  <= idx_q + LEN_W'(1);
                rem_q  <= rem_q - LEN_W'(1);
                addr_q <= next_addr;
                last_q <= (rem_q == LEN_W'(1));
            end
        end
    end

    assign beat_addr = addr_q;
    assign beat_id   = id_q;
    assign beat_idx  = idx_q;
    assign beat_last = last_q;
    assign q_count   = cnt;

endmodule

// File: tb/tb_axi_aw_burst_gen.sv
// Scoreboard bench for axi_aw_burst_gen: accepted AWs expand into expected beats, a monitor compares.
module tb_axi_aw_burst_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic        beat_valid;
    logic        beat_ready = 1'b0;
    logic [31:0] beat_addr;
    logic [3:0]  beat_id;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic [2:0]  q_count;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  idx;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    axi_aw_burst_gen #(
        .ID_W       (4),
        .LEN_W      (8),
        .ADDR_W     (32),
        .DATA_BYTES (4),
        .DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .awid       (awid),
        .awlen      (awlen),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_id    (beat_id),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .q_count    (q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a burst of len+1 beats, first at the raw address, rest at aligned base + k*4.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (awvalid && awready) begin
            for (int k = 0; k <= int'(awlen); k++) begin
                beat_t b;
                b.addr = (k == 0) ? awaddr : (awaddr & 32'hFFFF_FFFC) + 32'(k * 4);
                b.id   = awid;
                b.idx  = 8'(k);
                b.last = (k == int'(awlen));
                exp_q.push_back(b);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && beat_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got addr %0h id %0h, expected no beat at %0t",
                         beat_addr, beat_id, $time);
            end else begin
                chk("beat_addr", 64'(beat_addr), 64'(exp_q[0].addr));
                chk("beat_id",   64'(beat_id),   64'(exp_q[0].id));
                chk("beat_idx",  64'(beat_idx),  64'(exp_q[0].idx));
                chk("beat_last", 64'(beat_last), 64'(exp_q[0].last));
                if (beat_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_aw(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
        int n;
        awid    = id;
        awlen   = len;
        awaddr  = addr;
        awvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (awready) break;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL aw_timeout: awready got 0 expected 1");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(input logic [7:0] idx);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (beat_valid && beat_idx == idx) break;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL beat_timeout: idx %0d never seen, expected within 200 cycles", idx);
                break;
            end
        end
    endtask

    initial begin
        logic aw_acc;
        int   sent;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("awready_in_reset", 64'(awready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("rst_beat_addr",  64'(beat_addr),  64'd0);
        chk("rst_beat_id",    64'(beat_id),    64'd0);
        chk("rst_beat_idx",   64'(beat_idx),   64'd0);
        chk("rst_beat_last",  64'(beat_last),  64'd0);
        chk("rst_q_count",    64'(q_count),    64'd0);
        chk("rst_awready",    64'(awready),    64'd1);
        @(posedge clk);
        #1;

        // Single beat with latency check
        beat_ready = 1'b1;
        send_aw(4'd3, 8'd0, 32'h100);
        @(negedge clk);
        chk("lat_edge_n",  64'(beat_valid), 64'd0);
        @(negedge clk);
        chk("lat_edge_n1", 64'(beat_valid), 64'd0);
        @(negedge clk);
        chk("lat_edge_n2", 64'(beat_valid), 64'd1);
        drain();

        // INCR burst from unaligned start
        send_aw(4'd1, 8'd3, 32'h1002);
        drain();

        // Backpressure at idx 1
        beat_ready = 1'b0;
        send_aw(4'd1, 8'd3, 32'h1002);
        wait_beat(8'd0);
        @(posedge clk);
        #1 beat_ready = 1'b1;
        @(posedge clk);
        #1 beat_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 beat_ready = 1'b1;
        drain();

        // Full queue, then back-to-back release
        beat_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_aw(4'(i), 8'd1, 32'h4000 + 32'(i * 32'h100));
        end
        @(negedge clk);
        chk("full_q_count", 64'(q_count), 64'd4);
        chk("full_awready", 64'(awready), 64'd0);
        @(posedge clk);
        #1 beat_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("b2b_no_bubble", 64'(beat_valid), 64'd1);
        end
        @(negedge clk);
        chk("b2b_idle_after", 64'(beat_valid), 64'd0);
        drain();

        // Address wrap
        send_aw(4'd7, 8'd1, 32'hFFFF_FFFC);
        drain();

        // Randomized traffic with random backpressure
        aw_acc = 1'b0;
        sent   = 0;
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            if (aw_acc) begin
                awvalid = 1'b0;
                aw_acc  = 1'b0;
            end
            beat_ready = ($urandom_range(0, 3) != 0);
            if (!awvalid && sent < 40 && $urandom_range(0, 2) == 0) begin
                awid    = 4'($urandom);
                awlen   = 8'($urandom_range(0, 7));
                awaddr  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                      : 32'($urandom);
                awvalid = 1'b1;
                sent++;
            end
            @(negedge clk);
            if (awvalid && awready) aw_acc = 1'b1;
        end
        @(posedge clk);
        #1;
        awvalid    = 1'b0;
        beat_ready = 1'b1;
        drain();

        // Mid-burst reset discards active and queued bursts
        send_aw(4'd5, 8'd7, 32'h2000);
        send_aw(4'd6, 8'd2, 32'h3000);
        wait_beat(8'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_beat_valid", 64'(beat_valid), 64'd0);
        chk("mrst_q_count",    64'(q_count),    64'd0);
        chk("mrst_awready",    64'(awready),    64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mrst_no_beat", 64'(beat_valid), 64'd0);
        end

        // Engine recovers after reset
        @(posedge clk);
        #1;
        send_aw(4'd9, 8'd2, 32'h0000_0007);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
